// File: rtl/ld_str_ctrl.sv
// ld_str_ctrl: single-outstanding load/store controller between a CPU-side
// strobe interface and a level-acknowledged memory port. Every output is a
// flop, and a wait counter aborts requests that the memory never answers.
module ld_str_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic       wr,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] rdata,
    output logic       mem_req,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack
);

    // Counter value at which the request is abandoned; an ack on that same
    // edge still takes priority over the abort.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [7:0] rdata_q, rdata_d;
    logic       memReq_q, memReq_d;
    logic       memWe_q, memWe_d;
    logic [7:0] memAddr_q, memAddr_d;
    logic [7:0] memWdata_q, memWdata_d;

    // Next-state and next-output logic; every register holds unless a transition touches it.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        memReq_d   = memReq_q;
        memWe_d    = memWe_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;

        case (state_q)
            IDLE: begin
                // An ack still high from the last handshake blocks a new request.
                if (start && !mem_ack) begin
                    memWe_d    = wr;
                    memAddr_d  = addr;
                    memWdata_d = wdata;
                    memReq_d   = 1'b1;
                    busy_d     = 1'b1;
                    err_d      = 1'b0;
                    cnt_d      = 8'd0;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    memReq_d = 1'b0;
                    done_d   = 1'b1;
                    if (!memWe_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = DONE;
                end else if (cnt_q == LAST_WAIT) begin
                    memReq_d = 1'b0;
                    busy_d   = 1'b0;
                    err_d    = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; clr abandons any access immediately.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 8'd0;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= 8'd0;
            memWdata_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            memReq_q   <= memReq_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_req   = memReq_q;
    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;

endmodule

// File: doc/ld_str_ctrl.md
LD_STR_CTRL -- requirements
Module: ld_str_ctrl

Interface
- REQ-001 The block SHALL have one parameter: TIMEOUT, default 15, the maximum number of cycles mem_req waits for mem_ack before aborting (legal range 1..255).
- REQ-002 The port list SHALL be as follows, in this order:
  - clk  input  1  sole clock; all state changes on its rising edge.
  - clr  input  1  reset, asynchronous, active-low.
  - start  input  1  CPU request strobe, sampled on clk.
  - wr  input  1  access type, sampled with start; 1 = store, 0 = load.
  - addr  input  8  access address, sampled with start.
  - wdata  input  8  store data, sampled with start.
  - busy  output  1  high while an access is in progress.
  - done  output  1  one-cycle pulse on successful completion.
  - err  output  1  sticky timeout flag.
  - rdata  output  8  data from the last successful load.
  - mem_req  output  1  memory request; held until acknowledged or timed out.
  - mem_we  output  1  memory write enable; valid while mem_req is high.
  - mem_addr  output  8  memory address; valid while mem_req is high.
  - mem_wdata  output  8  memory write data; valid while mem_req is high.
  - mem_rdata  input  8  memory read data; valid when mem_ack is high.
  - mem_ack  input  1  memory acknowledge (level).
- REQ-003 All outputs SHALL be registered; no combinational path SHALL exist from any input to any output.

Function
- REQ-004 The FSM SHALL have exactly three states: IDLE, REQ and DONE.
- REQ-005 In IDLE, start=1 with mem_ack=0 SHALL:
  - capture wr, addr and wdata into mem_we, mem_addr and mem_wdata;
  - set mem_req=1 and busy=1;
  - clear err and the wait counter;
  - go to REQ.
- REQ-006 In IDLE, start=1 with mem_ack=1 SHALL be ignored (the previous handshake has not closed); the state SHALL remain IDLE.
- REQ-007 In REQ, mem_ack=1 SHALL, at that edge:
  - clear mem_req;
  - on a load (mem_we=0), load mem_rdata into rdata;
  - set done=1;
  - go to DONE.
- REQ-008 In REQ with mem_ack=0, the 8-bit wait counter SHALL increment by one per cycle. When it equals TIMEOUT-1 at an edge, that edge SHALL:
  - clear mem_req and busy;
  - set err=1;
  - leave rdata unchanged;
  - go to IDLE.
- REQ-009 In DONE, the next edge SHALL clear done and busy and return to IDLE; done SHALL be high for exactly one cycle per successful access.
- REQ-010 A store SHALL never modify rdata; rdata SHALL hold its value between successful loads.
- REQ-011 start SHALL be ignored in REQ and DONE; the captured access SHALL NOT change mid-transfer.
- REQ-012 mem_we, mem_addr and mem_wdata SHALL hold their captured values after mem_req falls, until the next accepted start.
- REQ-013 err SHALL remain 1 until the next accepted start or reset; done and err SHALL never both be 1.
- REQ-014 Minimum latency SHALL be 2 edges: start sampled at edge N, mem_ack sampled high at edge N+1, done high from N+1 to N+2.
- REQ-015 If mem_ack and the timeout condition coincide at the same edge, mem_ack SHALL win: the access completes successfully and err stays 0.

Reset
- REQ-016 clr=0 SHALL immediately, without waiting for clk:
  - force the FSM to IDLE;
  - clear the wait counter;
  - set busy, done, err, mem_req and mem_we to 0;
  - set rdata, mem_addr and mem_wdata to 0.
- REQ-017 Reset asserted mid-access SHALL abandon the access: mem_req drops asynchronously and no done pulse is produced.
- REQ-018 After clr rises, the first start SHALL be accepted at the first clk edge at which it is sampled high.

Verification
- REQ-019 Load: start, wr=0, addr=0x3C; memory acks with mem_rdata=0xA5 two cycles after mem_req rises -> mem_addr=0x3C and mem_we=0 while mem_req=1; rdata=0xA5; single done pulse; busy high for 4 cycles.
- REQ-020 Store: start, wr=1, addr=0x10, wdata=0x7E; immediate ack -> mem_we=1, mem_wdata=0x7E; rdata unchanged from the prior value 0xA5; done pulses 2 edges after start.
- REQ-021 Timeout: TIMEOUT=15, mem_ack held 0 -> mem_req drops after 15 cycles in REQ; err=1, no done pulse; the next accepted start clears err.
- REQ-022 Boundary: mem_ack rises on the same edge the counter hits 14 -> done=1, err=0, rdata updated.
- REQ-023 Ignore and block: start pulsed during REQ -> no effect on mem_addr; start in IDLE while mem_ack is still high -> not accepted, busy stays 0.
- REQ-024 Mid-access reset: clr pulsed low while mem_req=1 -> all outputs 0 within the same cycle; no done pulse; a fresh load after reset completes normally.
